// File: rtl/inst_prefetch_queue.sv
// inst_prefetch_queue
//
// Instruction fetch front end that sits in front of the IF/ID staging
// register. It fetches 32-bit instruction words from a variable-latency
// instruction memory using a req/ack handshake. Each fetched word is stored
// in a small FIFO together with its PC+4. The decode stage reads the words
// through a valid/ready interface. A redirect (taken branch or jump) flushes
// the queue and restarts fetch at the new address.
//
// Parameters:
//   DEPTH    FIFO entries (power of two, 2..16)
//   PCSTART  fetch address after reset
//
// Ports:
//   clk            clock; all state changes on the rising edge
//   reset          asynchronous, active-low reset
//   redirect       flush the queue and refetch from redirect_pc
//   redirect_pc    new fetch address (bits [1:0] are ignored)
//   imem_req       registered fetch request
//   imem_addr      registered word address of the request
//   imem_ack       one-cycle pulse; imem_rdata is valid in this cycle
//   imem_rdata     fetched instruction word
//   inst_valid     head entry is valid
//   inst_data      head instruction
//   inst_pc_plus4  fetch address of the head entry + 4
//   inst_ready     decode accepts the head entry (low = stall)
//   count          number of occupied FIFO entries
//
// Optional feature: define PREFETCH_BYPASS_EN to let an ack that arrives
// while the queue is empty reach decode in the same cycle. If decode accepts
// the word in that cycle, it is not written into the FIFO.

module inst_prefetch_queue #(
    parameter int unsigned DEPTH   = 4,
    parameter logic [31:0] PCSTART = 32'h0
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           redirect,
    input  logic [31:0]                    redirect_pc,
    output logic                           imem_req,
    output logic [31:0]                    imem_addr,
    input  logic                           imem_ack,
    input  logic [31:0]                    imem_rdata,
    output logic                           inst_valid,
    output logic [31:0]                    inst_data,
    output logic [31:0]                    inst_pc_plus4,
    input  logic                           inst_ready,
    output logic [$clog2(DEPTH+1)-1:0]     count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam logic [CW:0] DEPTH_W = DEPTH[CW:0];

    logic [31:0]   fetch_pc;
    logic          drop;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [31:0]   data_mem [DEPTH];
    logic [31:0]   pc4_mem  [DEPTH];

    logic [31:0]   redirect_base;
    logic [31:0]   ack_pc_plus4;
    logic [31:0]   fetch_pc_next;
    logic [CW:0]   count_plus;
    logic          acked;
    logic          ack_good;
    logic          push;
    logic          pop;
    logic          fifo_valid;
    logic          slot_free;
    logic          issue;

    // imem_req doubles as the outstanding flag: it is high exactly while
    // a request is waiting for its ack.
    assign redirect_base = redirect_pc & 32'hFFFF_FFFC;
    assign acked         = imem_req & imem_ack;
    assign ack_good      = acked & ~drop & ~redirect;
    assign ack_pc_plus4  = imem_addr + 32'd4;
    assign fifo_valid    = (count != '0);

`ifdef PREFETCH_BYPASS_EN
    // If the queue is empty, a good ack is forwarded straight to decode.
    // It is pushed into the FIFO only if decode does not take it.
    logic bypass;
    assign bypass        = ~fifo_valid & ack_good;
    assign inst_valid    = fifo_valid | bypass;
    assign inst_data     = bypass ? imem_rdata   : data_mem[rd_ptr];
    assign inst_pc_plus4 = bypass ? ack_pc_plus4 : pc4_mem[rd_ptr];
    assign push          = ack_good & ~(bypass & inst_ready);
`else
    assign inst_valid    = fifo_valid;
    assign inst_data     = data_mem[rd_ptr];
    assign inst_pc_plus4 = pc4_mem[rd_ptr];
    assign push          = ack_good;
`endif

    assign pop = fifo_valid & inst_ready & ~redirect;

    // The issue check counts the word that arrives this cycle but ignores
    // any pop in the same cycle. This reserves FIFO space for every
    // outstanding request, so a later ack always has a free entry.
    assign fetch_pc_next = redirect ? redirect_base :
                           (ack_good ? fetch_pc + 32'd4 : fetch_pc);
    assign count_plus    = {1'b0, count} + {{CW{1'b0}}, push};
    assign slot_free     = ~imem_req | imem_ack;
    assign issue         = slot_free & (redirect | (count_plus < DEPTH_W));

    // Control state: fetch address, request handshake, stale-ack tracking
    // and FIFO bookkeeping. Redirect has priority over push, pop and the
    // normal issue check. A redirect that arrives while a request is still
    // waiting marks that request's ack as stale, so its data is dropped.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc  <= PCSTART;
            imem_req  <= 1'b0;
            imem_addr <= PCSTART;
            drop      <= 1'b0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
        end else begin
            fetch_pc <= fetch_pc_next;

            if (issue) begin
                imem_req  <= 1'b1;
                imem_addr <= fetch_pc_next;
            end else if (acked) begin
                imem_req  <= 1'b0;
            end

            if (redirect) begin
                drop <= imem_req & ~imem_ack;
            end else if (acked) begin
                drop <= 1'b0;
            end

            if (redirect) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + PW'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PW'(1);
                end
                case ({push, pop})
                    2'b10:   count <= count + CW'(1);
                    2'b01:   count <= count - CW'(1);
                    default: count <= count;
                endcase
            end
        end
    end

    // FIFO storage has no reset; entries are read only while count says
    // they are valid.
    always_ff @(posedge clk) begin
        if (push) begin
            data_mem[wr_ptr] <= imem_rdata;
            pc4_mem[wr_ptr]  <= ack_pc_plus4;
        end
    end

endmodule

// File: tb/tb_inst_prefetch_queue.sv
// tb_inst_prefetch_queue
//
// Directed bench for inst_prefetch_queue (default build, DEPTH=4, PCSTART=0).
// A behavioural instruction memory answers each request after mem_lat idle
// cycles and returns rdata = addr ^ 32'hA5A5_0000.

module tb_inst_prefetch_queue;

    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          reset;
    logic          redirect;
    logic [31:0]   redirect_pc;
    logic          imem_req;
    logic [31:0]   imem_addr;
    logic          imem_ack = 1'b0;
    logic [31:0]   imem_rdata = 32'h0;
    logic          inst_valid;
    logic [31:0]   inst_data;
    logic [31:0]   inst_pc_plus4;
    logic          inst_ready;
    logic [CW-1:0] count;

    int n_checks = 0;
    int n_fail   = 0;
    int mem_lat  = 1;
    int mem_wait = 0;
    int reqs_served = 0;
    int k;

    inst_prefetch_queue #(
        .DEPTH   (DEPTH),
        .PCSTART (32'h0)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .redirect      (redirect),
        .redirect_pc   (redirect_pc),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .inst_valid    (inst_valid),
        .inst_data     (inst_data),
        .inst_pc_plus4 (inst_pc_plus4),
        .inst_ready    (inst_ready),
        .count         (count)
    );

    always #5 clk = ~clk;

    // Memory model. The ack is raised at the negedge once the request has
    // been visible for more than mem_lat cycles. It is held for one cycle
    // only. A request present right after an ack is a new request.
    always @(negedge clk) begin
        if (!reset) begin
            imem_ack    = 1'b0;
            mem_wait    = 0;
            reqs_served = 0;
        end else if (imem_ack) begin
            imem_ack = 1'b0;
            mem_wait = imem_req ? 1 : 0;
        end else if (imem_req) begin
            mem_wait++;
            if (mem_wait > mem_lat) begin
                imem_ack    = 1'b1;
                imem_rdata  = imem_addr ^ 32'hA5A5_0000;
                reqs_served++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic r, input logic [31:0] rpc, input logic rdy);
        redirect    = r;
        redirect_pc = rpc;
        inst_ready  = rdy;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Holds reset for two cycles, then releases it just after a posedge.
    // The next edge is the first edge after reset.
    task automatic doReset(input int lat, input logic rdy);
        reset = 1'b0;
        mem_lat = lat;
        applyStimulus(1'b0, 32'h0, rdy);
        tick();
        tick();
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b0;
        applyStimulus(1'b0, 32'h0, 1'b1);

        // Reset values and streaming with single-cycle latency.
        $display("[TB] reset and streaming");
        tick();
        checkOutput("rst_req",   32'(imem_req),   32'd0);
        checkOutput("rst_addr",  imem_addr,       32'h0);
        checkOutput("rst_valid", 32'(inst_valid), 32'd0);
        checkOutput("rst_count", 32'(count),      32'd0);
        doReset(1, 1'b1);
        k = 0;
        for (int c = 1; c <= 16; c++) begin
            tick();
            if (c == 1) begin
                checkOutput("t1_first_req",  32'(imem_req), 32'd1);
                checkOutput("t1_first_addr", imem_addr,     32'h0);
            end
            checkOutput("t1_valid", 32'(inst_valid), 32'((c >= 3) && (c % 2 == 1)));
            if ((c >= 3) && (c % 2 == 1)) begin
                checkOutput("t1_data", inst_data,     (32'(k) * 32'd4) ^ 32'hA5A5_0000);
                checkOutput("t1_pc4",  inst_pc_plus4, 32'(k) * 32'd4 + 32'd4);
                k++;
            end
        end
        checkOutput("t1_delivered", 32'(k), 32'd7);

        // Stall: with DEPTH entries reserved, fetch stops. Then drain.
        $display("[TB] stall and drain");
        doReset(1, 1'b0);
        repeat (20) tick();
        checkOutput("t2_reqs",  32'(reqs_served), 32'd4);
        checkOutput("t2_count", 32'(count),       32'd4);
        checkOutput("t2_req",   32'(imem_req),    32'd0);
        checkOutput("t2_valid", 32'(inst_valid),  32'd1);
        checkOutput("t2_head",  inst_data,        32'hA5A5_0000);
        applyStimulus(1'b0, 32'h0, 1'b1);
        k = 0;
        for (int i = 0; i < 10; i++) begin
            if (inst_valid) begin
                checkOutput("t2_data", inst_data,     (32'(k) * 32'd4) ^ 32'hA5A5_0000);
                checkOutput("t2_pc4",  inst_pc_plus4, 32'(k) * 32'd4 + 32'd4);
                k++;
            end
            tick();
        end
        checkOutput("t2_delivered", 32'(k), 32'd7);

        // Redirect while the request to 8 is waiting; its ack is dropped.
        $display("[TB] redirect with outstanding request");
        doReset(3, 1'b1);
        repeat (9) tick();
        checkOutput("t3_pre_addr", imem_addr,     32'h8);
        checkOutput("t3_pre_pc4",  inst_pc_plus4, 32'h8);
        applyStimulus(1'b1, 32'h40, 1'b1);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b1);
        checkOutput("t3_valid_n1", 32'(inst_valid), 32'd0);
        checkOutput("t3_count_n1", 32'(count),      32'd0);
        checkOutput("t3_addr_n1",  imem_addr,       32'h8);
        repeat (3) tick();
        checkOutput("t3_new_req",  32'(imem_req),   32'd1);
        checkOutput("t3_new_addr", imem_addr,       32'h40);
        checkOutput("t3_count",    32'(count),      32'd0);
        repeat (4) tick();
        checkOutput("t3_valid", 32'(inst_valid), 32'd1);
        checkOutput("t3_data",  inst_data,       32'hA5A5_0040);
        checkOutput("t3_pc4",   inst_pc_plus4,   32'h44);

        // Redirect and ack in the same cycle; low bits of redirect_pc are ignored.
        $display("[TB] redirect coincident with ack");
        doReset(1, 1'b1);
        tick();
        tick();
        applyStimulus(1'b1, 32'h103, 1'b1);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b1);
        checkOutput("t4_addr",  imem_addr,       32'h100);
        checkOutput("t4_req",   32'(imem_req),   32'd1);
        checkOutput("t4_count", 32'(count),      32'd0);
        checkOutput("t4_valid0", 32'(inst_valid), 32'd0);
        tick();
        checkOutput("t4_valid1", 32'(inst_valid), 32'd0);
        tick();
        checkOutput("t4_valid2", 32'(inst_valid), 32'd1);
        checkOutput("t4_data",   inst_data,       32'hA5A5_0100);
        checkOutput("t4_pc4",    inst_pc_plus4,   32'h104);

        // Address wrap at the top of the address space.
        $display("[TB] address wrap");
        doReset(1, 1'b1);
        tick();
        applyStimulus(1'b1, 32'hFFFF_FFFC, 1'b1);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b1);
        checkOutput("t5_stale_addr", imem_addr,       32'h0);
        checkOutput("t5_valid0",     32'(inst_valid), 32'd0);
        tick();
        checkOutput("t5_top_addr",   imem_addr,       32'hFFFF_FFFC);
        tick();
        tick();
        checkOutput("t5_valid", 32'(inst_valid), 32'd1);
        checkOutput("t5_data",  inst_data,       32'h5A5A_FFFC);
        checkOutput("t5_pc4",   inst_pc_plus4,   32'h0);
        checkOutput("t5_next",  imem_addr,       32'h0);
        checkOutput("t5_req",   32'(imem_req),   32'd1);

        // Asynchronous reset while a request is waiting and three entries are held.
        $display("[TB] asynchronous reset mid-request");
        doReset(1, 1'b0);
        repeat (7) tick();
        checkOutput("t6_pre_count", 32'(count),   32'd3);
        checkOutput("t6_pre_addr",  imem_addr,    32'hC);
        reset = 1'b0;
        #1;
        checkOutput("t6_req",   32'(imem_req),   32'd0);
        checkOutput("t6_addr",  imem_addr,       32'h0);
        checkOutput("t6_valid", 32'(inst_valid), 32'd0);
        checkOutput("t6_count", 32'(count),      32'd0);
        tick();
        reset = 1'b1;
        tick();
        checkOutput("t6_first_req",  32'(imem_req),   32'd1);
        checkOutput("t6_first_addr", imem_addr,       32'h0);
        checkOutput("t6_first_cnt",  32'(count),      32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
